// File: rtl/block_process_engine_if.sv
// Bus bundle for block_process_engine: job control, source fetch port and
// addressed readout port.
interface block_process_engine_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  logic              start;
  logic [1:0]        mode;
  logic [DATA_W-1:0] key;
  logic [ADDR_W-1:0] data_in_addr;
  logic [DATA_W-1:0] data_in;
  logic [ADDR_W-1:0] data_out_addr;
  logic              rd_en;
  logic [DATA_W-1:0] data_out;
  logic              busy;
  logic              done;
  logic [3:0]        state_out;

  modport master (
    output start, mode, key, data_in, data_out_addr, rd_en,
    input  data_in_addr, data_out, busy, done, state_out
  );

  modport slave (
    input  start, mode, key, data_in, data_out_addr, rd_en,
    output data_in_addr, data_out, busy, done, state_out
  );
endinterface

// File: rtl/block_process_engine.sv
// Load/process/save engine: fetches DEPTH words, transforms them in place with
// the operation latched at start, then serves addressed reads until DEPTH are consumed.
module block_process_engine #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 8
) (
  input logic                    clk,
  input logic                    rst_n,
  block_process_engine_if.slave  bus_io
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    LOAD    = 4'd1,
    PROCESS = 4'd2,
    SAVE    = 4'd3,
    DONE    = 4'd4
  } state_e;

  state_e            state_q, state_d;
  logic              last_start_q;
  logic [1:0]        mode_q, mode_d;
  logic [DATA_W-1:0] key_q, key_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              wr_en_s;
  logic [IDX_W-1:0]  wr_idx_s;
  logic [DATA_W-1:0] wr_data_s;
  logic [DATA_W-1:0] cur_word_s;
  logic [CNT_W-1:0]  cnt_dec_s;
  logic [CNT_W-1:0]  rd_cnt_inc_s;

  function automatic logic [DATA_W-1:0] apply_op(
    input logic [1:0]        op,
    input logic [DATA_W-1:0] x,
    input logic [DATA_W-1:0] k
  );
    case (op)
      2'd0:    apply_op = ~x;
      2'd1:    apply_op = x;
      2'd2:    apply_op = x ^ k;
      2'd3:    apply_op = x + k;
      default: apply_op = x;
    endcase
  endfunction

  assign cnt_dec_s    = cnt_q - ONE_C;
  assign rd_cnt_inc_s = rd_cnt_q + ONE_C;
  assign cur_word_s   = mem_q[cnt_q[IDX_W-1:0]];

  // Next-state, counter and buffer write-port decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_cnt_d  = rd_cnt_q;
    mode_d    = mode_q;
    key_d     = key_q;
    wr_en_s   = 1'b0;
    wr_idx_s  = '0;
    wr_data_s = '0;
    case (state_q)
      IDLE: begin
        if (bus_io.start && !last_start_q) begin
          state_d  = LOAD;
          cnt_d    = '0;
          rd_cnt_d = '0;
          mode_d   = bus_io.mode;
          key_d    = bus_io.key;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        // Source data lags its address by one cycle, so write the previous slot.
        if (cnt_q != '0) begin
          wr_en_s   = 1'b1;
          wr_idx_s  = cnt_dec_s[IDX_W-1:0];
          wr_data_s = bus_io.data_in;
        end else begin
          wr_en_s = 1'b0;
        end
        if (cnt_q == DEPTH_C) begin
          state_d = PROCESS;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      PROCESS: begin
        wr_en_s   = 1'b1;
        wr_idx_s  = cnt_q[IDX_W-1:0];
        wr_data_s = apply_op(mode_q, cur_word_s, key_q);
        if (cnt_q == LAST_C) begin
          state_d = SAVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      SAVE: begin
        if (bus_io.rd_en) begin
          rd_cnt_d = rd_cnt_inc_s;
          if (rd_cnt_inc_s == DEPTH_C) begin
            state_d = DONE;
          end else begin
            state_d = SAVE;
          end
        end else begin
          state_d = SAVE;
        end
      end
      DONE: begin
        if (!last_start_q) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        rd_cnt_d = '0;
      end
    endcase
  end

  // Control state, counters and latched job parameters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_start_q <= 1'b0;
      mode_q       <= 2'd0;
      key_q        <= '0;
      cnt_q        <= '0;
      rd_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_start_q <= bus_io.start;
      mode_q       <= mode_d;
      key_q        <= key_d;
      cnt_q        <= cnt_d;
      rd_cnt_q     <= rd_cnt_d;
    end
  end

  // Word buffer; cleared by reset so an aborted job leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_s) begin
      mem_q[wr_idx_s] <= wr_data_s;
    end
  end

  assign bus_io.data_in_addr = ((state_q == LOAD) && (cnt_q < DEPTH_C)) ?
                               cnt_q[ADDR_W-1:0] : '0;
  assign bus_io.data_out     = ({1'b0, bus_io.data_out_addr} < DEPTH_C) ?
                               mem_q[bus_io.data_out_addr[IDX_W-1:0]] : '0;
  assign bus_io.busy         = (state_q == LOAD) || (state_q == PROCESS) ||
                               (state_q == SAVE);
  assign bus_io.done         = (state_q == DONE);
  assign bus_io.state_out    = state_q;
endmodule

// File: tb/tb_block_process_engine.sv
// Directed bench for block_process_engine: three instances (DEPTH 8, 4, 64)
// each fed by a synchronous-read source model.
module tb_block_process_engine;
  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_LOAD = 4'd1;
  localparam logic [3:0] S_PROC = 4'd2;
  localparam logic [3:0] S_SAVE = 4'd3;
  localparam logic [3:0] S_DONE = 4'd4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  logic [31:0] src8  [256];
  logic [31:0] src4  [256];
  logic [31:0] src64 [256];

  always #5 clk = ~clk;

  block_process_engine_if #(.DATA_W(32), .ADDR_W(8)) if8  ();
  block_process_engine_if #(.DATA_W(32), .ADDR_W(8)) if4  ();
  block_process_engine_if #(.DATA_W(32), .ADDR_W(8)) if64 ();

  block_process_engine #(.DATA_W(32), .DEPTH(8),  .ADDR_W(8)) u8  (.clk(clk), .rst_n(rst_n), .bus_io(if8));
  block_process_engine #(.DATA_W(32), .DEPTH(4),  .ADDR_W(8)) u4  (.clk(clk), .rst_n(rst_n), .bus_io(if4));
  block_process_engine #(.DATA_W(32), .DEPTH(64), .ADDR_W(8)) u64 (.clk(clk), .rst_n(rst_n), .bus_io(if64));

  always @(posedge clk) begin
    if8.data_in  <= src8[if8.data_in_addr];
    if4.data_in  <= src4[if4.data_in_addr];
    if64.data_in <= src64[if64.data_in_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start4(input logic [1:0] m, input logic [31:0] k);
    if4.mode  = m;
    if4.key   = k;
    if4.start = 1'b1;
    tick();
    if4.start = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 256; i++) begin
      src8[i] = 32'h0; src4[i] = 32'h0; src64[i] = 32'h0;
    end
    if8.start = 1'b0;  if8.mode = 2'd0;  if8.key = 32'h0;  if8.data_out_addr = 8'd0;  if8.rd_en = 1'b0;
    if4.start = 1'b0;  if4.mode = 2'd0;  if4.key = 32'h0;  if4.data_out_addr = 8'd0;  if4.rd_en = 1'b0;
    if64.start = 1'b0; if64.mode = 2'd0; if64.key = 32'h0; if64.data_out_addr = 8'd0; if64.rd_en = 1'b0;
    rst_n = 1'b0;
    repeat (2) tick();
    checks++; if (if8.state_out !== S_IDLE) begin failures++; $display("FAIL reset_state8 got=%0d exp=%0d", if8.state_out, S_IDLE); end
    checks++; if (if8.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", if8.busy); end
    checks++; if (if8.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", if8.done); end
    checks++; if (if8.data_in_addr !== 8'd0) begin failures++; $display("FAIL reset_in_addr got=%0d exp=0", if8.data_in_addr); end
    checks++; if (if8.data_out !== 32'h0) begin failures++; $display("FAIL reset_data_out got=%h exp=0", if8.data_out); end
    checks++; if (if4.state_out !== S_IDLE) begin failures++; $display("FAIL reset_state4 got=%0d exp=%0d", if4.state_out, S_IDLE); end
    checks++; if (if64.state_out !== S_IDLE) begin failures++; $display("FAIL reset_state64 got=%0d exp=%0d", if64.state_out, S_IDLE); end
    rst_n = 1'b1;
    tick();
    checks++; if (if4.state_out !== S_IDLE) begin failures++; $display("FAIL post_reset_idle got=%0d exp=%0d", if4.state_out, S_IDLE); end
  endtask

  task automatic test_invert();
    logic [3:0] exp_st;
    for (int i = 0; i < 8; i++) src8[i] = 32'h1000_0000 + 32'(i);
    if8.mode  = 2'd0;
    if8.key   = 32'hA5A5_A5A5;
    if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    checks++; if (if8.state_out !== S_LOAD || if8.busy !== 1'b1) begin failures++; $display("FAIL inv_first_load got=%0d/%b exp=%0d/1", if8.state_out, if8.busy, S_LOAD); end
    for (int n = 2; n <= 18; n++) begin
      tick();
      exp_st = (n <= 9) ? S_LOAD : ((n <= 17) ? S_PROC : S_SAVE);
      checks++; if (if8.state_out !== exp_st) begin failures++; $display("FAIL inv_state_T+%0d got=%0d exp=%0d", n, if8.state_out, exp_st); end
    end
    for (int i = 0; i < 8; i++) begin
      if8.data_out_addr = 8'(i);
      if8.rd_en = 1'b1;
      #1;
      checks++; if (if8.data_out !== 32'hEFFF_FFFF - 32'(i)) begin failures++; $display("FAIL inv_word%0d got=%h exp=%h", i, if8.data_out, 32'hEFFF_FFFF - 32'(i)); end
      tick();
      exp_st = (i < 7) ? S_SAVE : S_DONE;
      checks++; if (if8.state_out !== exp_st) begin failures++; $display("FAIL inv_read%0d_state got=%0d exp=%0d", i, if8.state_out, exp_st); end
    end
    checks++; if (if8.done !== 1'b1) begin failures++; $display("FAIL inv_done got=%b exp=1", if8.done); end
    if8.rd_en = 1'b0;
    tick();
    checks++; if (if8.state_out !== S_IDLE || if8.done !== 1'b0) begin failures++; $display("FAIL inv_back_idle got=%0d/%b exp=0/0", if8.state_out, if8.done); end
  endtask

  task automatic test_xor_add();
    logic [31:0] exp_x [4];
    logic [31:0] exp_a [4];
    exp_x = '{32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 32'hFFFF_FFFB};
    exp_a = '{32'h0000_0000, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003};
    for (int i = 0; i < 4; i++) src4[i] = 32'(i + 1);
    pulse_start4(2'd2, 32'hFFFF_FFFF);
    if4.mode = 2'd3;
    if4.key  = 32'h0;
    repeat (9) tick();
    checks++; if (if4.state_out !== S_SAVE) begin failures++; $display("FAIL xor_save got=%0d exp=%0d", if4.state_out, S_SAVE); end
    for (int i = 0; i < 4; i++) begin
      if4.data_out_addr = 8'(i);
      if4.rd_en = 1'b1;
      #1;
      checks++; if (if4.data_out !== exp_x[i]) begin failures++; $display("FAIL xor_word%0d got=%h exp=%h", i, if4.data_out, exp_x[i]); end
      tick();
    end
    if4.rd_en = 1'b0;
    checks++; if (if4.state_out !== S_DONE) begin failures++; $display("FAIL xor_done got=%0d exp=%0d", if4.state_out, S_DONE); end
    tick();
    pulse_start4(2'd3, 32'hFFFF_FFFF);
    if4.mode = 2'd0;
    if4.key  = 32'h5555_5555;
    repeat (9) tick();
    checks++; if (if4.state_out !== S_SAVE) begin failures++; $display("FAIL add_save got=%0d exp=%0d", if4.state_out, S_SAVE); end
    for (int i = 0; i < 4; i++) begin
      if4.data_out_addr = 8'(i);
      if4.rd_en = 1'b1;
      #1;
      checks++; if (if4.data_out !== exp_a[i]) begin failures++; $display("FAIL add_word%0d got=%h exp=%h", i, if4.data_out, exp_a[i]); end
      tick();
    end
    if4.rd_en = 1'b0;
    checks++; if (if4.state_out !== S_DONE) begin failures++; $display("FAIL add_done got=%0d exp=%0d", if4.state_out, S_DONE); end
    tick();
  endtask

  task automatic test_start_held();
    logic [3:0] exp_st;
    if4.mode  = 2'd1;
    if4.key   = 32'h0;
    if4.start = 1'b1;
    tick();
    for (int n = 1; n <= 10; n++) begin
      if (n > 1) tick();
      exp_st = (n <= 5) ? S_LOAD : ((n <= 9) ? S_PROC : S_SAVE);
      checks++; if (if4.state_out !== exp_st) begin failures++; $display("FAIL held_state_T+%0d got=%0d exp=%0d", n, if4.state_out, exp_st); end
      if (n == 6) if4.start = 1'b0;
      if (n == 7) if4.start = 1'b1;
    end
    for (int i = 0; i < 4; i++) begin
      if4.data_out_addr = 8'(i);
      if4.rd_en = 1'b1;
      #1;
      checks++; if (if4.data_out !== 32'(i + 1)) begin failures++; $display("FAIL pass4_word%0d got=%h exp=%h", i, if4.data_out, 32'(i + 1)); end
      tick();
    end
    if4.rd_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (if4.state_out !== S_DONE || if4.busy !== 1'b0) begin failures++; $display("FAIL held_stay_done%0d got=%0d/%b exp=%0d/0", k, if4.state_out, if4.busy, S_DONE); end
    end
    if4.start = 1'b0;
    tick();
    checks++; if (if4.state_out !== S_DONE) begin failures++; $display("FAIL held_release_lag got=%0d exp=%0d", if4.state_out, S_DONE); end
    tick();
    checks++; if (if4.state_out !== S_IDLE) begin failures++; $display("FAIL held_to_idle got=%0d exp=%0d", if4.state_out, S_IDLE); end
    tick();
    checks++; if (if4.state_out !== S_IDLE) begin failures++; $display("FAIL held_no_queue got=%0d exp=%0d", if4.state_out, S_IDLE); end
  endtask

  task automatic test_rd_ignore();
    logic [7:0] addrs [4];
    logic [3:0] exp_st;
    addrs = '{8'd9, 8'd0, 8'd1, 8'd2};
    if4.rd_en = 1'b1;
    repeat (2) tick();
    if4.rd_en = 1'b0;
    pulse_start4(2'd1, 32'h0);
    repeat (6) tick();
    if4.rd_en = 1'b1;
    tick();
    if4.rd_en = 1'b0;
    repeat (2) tick();
    checks++; if (if4.state_out !== S_SAVE) begin failures++; $display("FAIL rdig_save got=%0d exp=%0d", if4.state_out, S_SAVE); end
    for (int i = 0; i < 4; i++) begin
      if4.data_out_addr = addrs[i];
      if4.rd_en = 1'b1;
      #1;
      if (i == 0) begin
        checks++; if (if4.data_out !== 32'h0) begin failures++; $display("FAIL rdig_oob_read got=%h exp=0", if4.data_out); end
      end else begin
        checks++; if (if4.data_out !== 32'(i)) begin failures++; $display("FAIL rdig_word%0d got=%h exp=%h", i, if4.data_out, 32'(i)); end
      end
      tick();
      exp_st = (i < 3) ? S_SAVE : S_DONE;
      checks++; if (if4.state_out !== exp_st) begin failures++; $display("FAIL rdig_read%0d_state got=%0d exp=%0d", i, if4.state_out, exp_st); end
    end
    if4.rd_en = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp_f [4];
    exp_f = '{32'h0000_00F1, 32'h0000_00F2, 32'h0000_00F3, 32'h0000_00F4};
    pulse_start4(2'd2, 32'h0000_00F0);
    repeat (2) tick();
    checks++; if (if4.data_in_addr !== 8'd2) begin failures++; $display("FAIL rstm_pre_addr got=%0d exp=2", if4.data_in_addr); end
    rst_n = 1'b0;
    #1;
    checks++; if (if4.state_out !== S_IDLE) begin failures++; $display("FAIL rstm_state got=%0d exp=0", if4.state_out); end
    checks++; if (if4.busy !== 1'b0 || if4.done !== 1'b0) begin failures++; $display("FAIL rstm_flags got=%b/%b exp=0/0", if4.busy, if4.done); end
    checks++; if (if4.data_in_addr !== 8'd0) begin failures++; $display("FAIL rstm_in_addr got=%0d exp=0", if4.data_in_addr); end
    if4.data_out_addr = 8'd0;
    #1;
    checks++; if (if4.data_out !== 32'h0) begin failures++; $display("FAIL rstm_buf0 got=%h exp=0", if4.data_out); end
    if4.data_out_addr = 8'd1;
    #1;
    checks++; if (if4.data_out !== 32'h0) begin failures++; $display("FAIL rstm_buf1 got=%h exp=0", if4.data_out); end
    checks++; if (if8.data_out !== 32'h0) begin failures++; $display("FAIL rstm_buf8 got=%h exp=0", if8.data_out); end
    tick();
    rst_n = 1'b1;
    tick();
    pulse_start4(2'd2, 32'h0000_00F0);
    repeat (9) tick();
    checks++; if (if4.state_out !== S_SAVE) begin failures++; $display("FAIL rstm_fresh_save got=%0d exp=%0d", if4.state_out, S_SAVE); end
    for (int i = 0; i < 4; i++) begin
      if4.data_out_addr = 8'(i);
      if4.rd_en = 1'b1;
      #1;
      checks++; if (if4.data_out !== exp_f[i]) begin failures++; $display("FAIL rstm_word%0d got=%h exp=%h", i, if4.data_out, exp_f[i]); end
      tick();
    end
    if4.rd_en = 1'b0;
    checks++; if (if4.done !== 1'b1) begin failures++; $display("FAIL rstm_done got=%b exp=1", if4.done); end
    tick();
  endtask

  task automatic test_pass64();
    logic [7:0] exp_addr;
    logic [3:0] exp_st;
    for (int i = 0; i < 64; i++) src64[i] = $urandom;
    if64.mode  = 2'd1;
    if64.key   = 32'hDEAD_BEEF;
    if64.start = 1'b1;
    tick();
    if64.start = 1'b0;
    for (int n = 1; n <= 130; n++) begin
      if (n > 1) tick();
      exp_addr = (n <= 64) ? 8'(n - 1) : 8'd0;
      exp_st   = (n <= 65) ? S_LOAD : ((n <= 129) ? S_PROC : S_SAVE);
      checks++; if (if64.data_in_addr !== exp_addr) begin failures++; $display("FAIL p64_addr_T+%0d got=%0d exp=%0d", n, if64.data_in_addr, exp_addr); end
      checks++; if (if64.state_out !== exp_st) begin failures++; $display("FAIL p64_state_T+%0d got=%0d exp=%0d", n, if64.state_out, exp_st); end
    end
    for (int i = 0; i < 64; i++) begin
      if64.data_out_addr = 8'(i);
      if64.rd_en = 1'b1;
      #1;
      checks++; if (if64.data_out !== src64[i]) begin failures++; $display("FAIL p64_word%0d got=%h exp=%h", i, if64.data_out, src64[i]); end
      tick();
    end
    if64.rd_en = 1'b0;
    checks++; if (if64.state_out !== S_DONE) begin failures++; $display("FAIL p64_done got=%0d exp=%0d", if64.state_out, S_DONE); end
    tick();
  endtask

  initial begin
    test_reset();
    test_invert();
    test_xor_add();
    test_start_held();
    test_rd_ignore();
    test_reset_mid();
    test_pass64();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
